// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake between a PS/2 command source and ps2_host_tx
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (optional PS2_TX_RETRY_EN: one silent retry)
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 3000,
  parameter int TIMEOUT_CYC = 375000,
  parameter int FILT_LEN    = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         ps2clk_i,
  input  logic         ps2dat_i,
  output logic         ps2clk_oe,
  output logic         ps2dat_oe,
  ps2_host_tx_if.slave tx
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [IW-1:0] InhLast  = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] ToLast   = TW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0] FiltLast = FW'(FILT_LEN - 1);
`ifdef PS2_TX_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_filt_q, clk_filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic          clk_s, dat_s, fall;

  state_t        state_q;
  logic          clk_oe_q, dat_oe_q, tx_ready_q, busy_q, done_q, err_q;
  logic [7:0]    shreg_q;
  logic          par_q, retry_q;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] inh_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [FW-1:0] idle_cnt_q;
  logic          timeout_w, nack_w, fail_w, retry_ok;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_filt_prev_q & ~clk_filt_q;

  // Line idles high, so synchronizers and filter come out of reset at 1.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      clk_sync_q      <= 2'b11;
      dat_sync_q      <= 2'b11;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], ps2clk_i};
      dat_sync_q      <= {dat_sync_q[0], ps2dat_i};
      clk_filt_prev_q <= clk_filt_q;
      if (clk_s == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltLast) begin
        clk_filt_q <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // An ACK-state fall always beats a simultaneous timeout.
  assign timeout_w = (state_q == S_SHIFT || state_q == S_ACK) && !fall && (to_cnt_q == ToLast);
  assign nack_w    = (state_q == S_ACK) && fall && dat_s;
  assign fail_w    = timeout_w || nack_w;
  assign retry_ok  = RetryEn && !retry_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      retry_q    <= 1'b0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      idle_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == S_SHIFT || state_q == S_ACK) to_cnt_q <= to_cnt_q + 1'b1;
      if (fail_w) begin
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        if (retry_ok) begin
          retry_q   <= 1'b1;
          inh_cnt_q <= '0;
          clk_oe_q  <= 1'b1;
          state_q   <= S_INHIBIT;
        end else begin
          err_q <= 1'b1;
          if (nack_w) begin
            idle_cnt_q <= '0;
            state_q    <= S_WAIT_IDLE;
          end else begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: if (tx.tx_valid) begin
            shreg_q    <= tx.tx_data;
            par_q      <= ~^tx.tx_data;
            retry_q    <= 1'b0;
            inh_cnt_q  <= '0;
            clk_oe_q   <= 1'b1;
            dat_oe_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_INHIBIT;
          end
          S_INHIBIT: if (inh_cnt_q == InhLast) begin
            dat_oe_q <= 1'b1;
            state_q  <= S_REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
          S_REQ: begin
            clk_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            state_q   <= S_SHIFT;
          end
          S_SHIFT: if (fall) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q < 4'd8) begin
              dat_oe_q <= ~shreg_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              dat_oe_q <= ~par_q;
            end else begin
              dat_oe_q <= 1'b0;
              state_q  <= S_ACK;
            end
          end
          S_ACK: if (fall) begin
            done_q     <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: if (clk_filt_q && dat_s) begin
            if (idle_cnt_q == FiltLast) begin
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2clk_oe   = clk_oe_q;
  assign ps2dat_oe   = dat_oe_q;
  assign tx.tx_ready = tx_ready_q;
  assign tx.busy     = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int TMO  = 2500;
  localparam int FL   = 8;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2clk_oe, ps2dat_oe;
  logic ps2clk_line, ps2dat_line;

  assign ps2clk_line = !(ps2clk_oe || dev_clk_low);
  assign ps2dat_line = !(ps2dat_oe || dev_dat_low);

  ps2_host_tx_if txif ();

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(FL)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .ps2clk_i  (ps2clk_line),
    .ps2dat_i  (ps2dat_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .tx        (txif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (txif.tx_done) done_cnt++;
    if (txif.tx_err) err_cnt++;
    if (txif.tx_done && txif.tx_err) both_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Wire order as the device sees it: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = ((ones % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit nack, input bit glitch, input int reset_at,
                           output logic [10:0] seen, output int inh_len, output bit ok);
    int n;
    ok = 1'b1;
    seen = '0;
    inh_len = 0;
    @(negedge clk);
    txif.tx_data = d;
    txif.tx_valid = 1'b1;
    @(negedge clk);
    txif.tx_valid = 1'b0;
    chk("ready_drop", {31'd0, txif.tx_ready}, 32'd0);
    chk("busy_in_frame", {31'd0, txif.busy}, 32'd1);
    n = 0;
    while (ps2clk_oe && n < 5000) begin
      inh_len++;
      n++;
      @(negedge clk);
    end
    if (ps2clk_oe) begin
      ok = 1'b0;
      return;
    end
    seen[0] = ps2dat_line;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_dat_low = !nack;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (reset_at == k) begin
        #2 nreset = 1'b0;
        #1;
        chk("rst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
        chk("rst_dat_oe", {31'd0, ps2dat_oe}, 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, txif.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, txif.busy}, 32'd0);
        return;
      end
      dev_clk_low = 1'b0;
      if (k <= 10) seen[k] = ps2dat_line;
      if (glitch && k == 5) begin
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b1;
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b0;
      end
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    n = 0;
    while (!txif.tx_ready && n < 10000) begin
      n++;
      @(negedge clk);
    end
    if (!txif.tx_ready) ok = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         glitch;
    int         exp_done;
    int         exp_err;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    logic [10:0] seen;
    logic [7:0]  d;
    int          inh_len, d0, e0, cnt;
    bit          ok, saw_inh, oe_at_err, ready_at_err;

    vecs[0] = '{8'hED, 1'b0, 1'b0, 1, 0};
    vecs[1] = '{8'h07, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1, 0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1, 0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 0, 1};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, 1, 0};

    txif.tx_data = 8'h00;
    txif.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
    chk("reset_dat_oe", {31'd0, ps2dat_oe}, 32'd0);
    chk("reset_ready", {31'd0, txif.tx_ready}, 32'd1);
    chk("reset_busy", {31'd0, txif.busy}, 32'd0);
    chk("reset_done", {31'd0, txif.tx_done}, 32'd0);
    chk("reset_err", {31'd0, txif.tx_err}, 32'd0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[i].data, vecs[i].nack, vecs[i].glitch, 0, seen, inh_len, ok);
      chk($sformatf("vec%0d_complete", i), {31'd0, ok}, 32'd1);
      chk($sformatf("vec%0d_bits", i), {21'd0, seen}, {21'd0, model_frame(vecs[i].data)});
      chk($sformatf("vec%0d_inhibit", i), inh_len, INH + 1);
      chk($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_busy_after", i), {31'd0, txif.busy}, 32'd0);
      repeat (20) @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      d0 = done_cnt;
      run_frame(d, 1'b0, 1'b0, 0, seen, inh_len, ok);
      chk($sformatf("rand%0d_bits_%02h", i, d), {21'd0, seen}, {21'd0, model_frame(d)});
      chk($sformatf("rand%0d_done", i), done_cnt - d0, 1);
      repeat (20) @(negedge clk);
    end

    // Device never clocks: the frame must time out.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    txif.tx_data = 8'hF4;
    txif.tx_valid = 1'b1;
    @(negedge clk);
    txif.tx_valid = 1'b0;
    cnt = 0;
    while (ps2clk_oe && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    cnt = 0;
    saw_inh = 1'b0;
    while (!txif.tx_err && cnt < 20000) begin
      @(negedge clk);
      cnt++;
      if (ps2clk_oe) saw_inh = 1'b1;
    end
    oe_at_err = ps2clk_oe || ps2dat_oe;
    ready_at_err = txif.tx_ready;
`ifdef PS2_TX_RETRY_EN
    chk("timeout_cycles", cnt, 2 * TMO + INH + 1);
    chk("timeout_retry_inhibit", {31'd0, saw_inh}, 32'd1);
`else
    chk("timeout_cycles", cnt, TMO);
    chk("timeout_retry_inhibit", {31'd0, saw_inh}, 32'd0);
`endif
    chk("timeout_oe_released", {31'd0, oe_at_err}, 32'd0);
    chk("timeout_ready", {31'd0, ready_at_err}, 32'd1);
    @(negedge clk);
    chk("timeout_err_pulse_width", {31'd0, txif.tx_err}, 32'd0);
    chk("timeout_err_count", err_cnt - e0, 1);
    chk("timeout_no_done", done_cnt - d0, 0);
    repeat (20) @(negedge clk);

    // Reset during bit 4, then a clean 0xF3 frame.
    run_frame(8'hA5, 1'b0, 1'b0, 5, seen, inh_len, ok);
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    run_frame(8'hF3, 1'b0, 1'b0, 0, seen, inh_len, ok);
    chk("post_reset_complete", {31'd0, ok}, 32'd1);
    chk("post_reset_bits", {21'd0, seen}, {21'd0, model_frame(8'hF3)});
    chk("post_reset_done", done_cnt - d0, 1);

    chk("never_done_and_err", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
